// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder BIST controller: FSM encoding,
// sweep geometry defaults and counter widths.
package fa_bist_pkg;

  localparam int SETTLE_DEF = 4;  // default dwell cycles per vector
  localparam int NVEC_DEF   = 8;  // exhaustive sweep of a 3-input adder
  localparam int IDX_W      = 3;
  localparam int ERR_W      = 4;
  localparam int DWELL_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_ref_model.sv
// Golden full-adder used to derive the expected sum and carry for the
// vector currently applied to the unit under test.
module fa_ref_model (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D_exp,
  output logic E_exp
);

  assign D_exp = A ^ B ^ C;
  assign E_exp = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/fa_bist.sv
// Exhaustive full-adder BIST: sweeps all eight {A,B,C} vectors, holds each
// for SETTLE cycles, samples D/E on the last dwell cycle and reports result.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int NVEC   = NVEC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             D,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] fail_vec
);

  if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
    $error("fa_bist: SETTLE must lie in 2..15");
  end
  if (NVEC != (1 << IDX_W)) begin : g_bad_nvec
    $error("fa_bist: NVEC must equal 8");
  end

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NVEC - 1);

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [DWELL_W-1:0] dwell_q,    dwell_d;
  logic [IDX_W-1:0]   vec_q,      vec_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               pass_q,     pass_d;
  logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;
  logic [IDX_W-1:0]   fail_vec_q, fail_vec_d;

  logic d_exp;
  logic e_exp;
  logic sample;
  logic mismatch;

  // Reference is fed from the registered vector, so it matches what the UUT sees.
  fa_ref_model u_ref (
    .A     (vec_q[2]),
    .B     (vec_q[1]),
    .C     (vec_q[0]),
    .D_exp (d_exp),
    .E_exp (e_exp)
  );

  assign sample   = (state_q == APPLY) && (dwell_q == DWELL_LAST);
  assign mismatch = (D != d_exp) || (E != e_exp);

  always_comb begin
    // NOTE: every _d starts from its _q (done from 0) so no branch leaves a
    // signal unassigned and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = APPLY;
          idx_d      = '0;
          dwell_d    = '0;
          vec_d      = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
        end
      end

      APPLY: begin
        if (sample) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
            if (err_cnt_q == '0) begin
              fail_vec_d = vec_q;
            end
          end
          dwell_d = '0;
          if (idx_q == IDX_LAST) begin
            // Pass must reflect the last vector's verdict, hence err_cnt_d.
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            idx_d = idx_q + IDX_W'(1);
            vec_d = idx_q + IDX_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dwell_q    <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign A        = vec_q[2];
  assign B        = vec_q[1];
  assign C        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_fa_bist.sv
// Scoreboard bench for fa_bist: stimulus pushes each sweep's expected result,
// a monitor checks vector timing every cycle and pops on each done pulse.
module tb_fa_bist;

  localparam int S = 4;

  typedef enum int {UUT_GOOD, UUT_E_STUCK0, UUT_D_INV_101} uut_mode_e;

  typedef struct {
    int done_cyc;
    int err;
    int fvec;
    int pass;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       A, B, C;
  logic       D, E;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;

  uut_mode_e mode     = UUT_GOOD;
  int        cyc      = 0;
  int        n_checks = 0;
  int        n_fail   = 0;
  exp_t      sb_q[$];
  bit        active   = 1'b0;
  int        k_start  = 0;

  logic       mon_busy_exp;
  logic [2:0] mon_vec_exp;
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Full-adder UUT with optional planted defects.
  always_comb begin
    D = A ^ B ^ C;
    E = (A & B) | (A & C) | (B & C);
    if (mode == UUT_E_STUCK0) E = 1'b0;
    if (mode == UUT_D_INV_101 && {A, B, C} == 3'b101) D = ~D;
  end

  fa_bist #(.SETTLE(S), .NVEC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .E        (E),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    mon_busy_exp = active && (cyc >= k_start + 1) && (cyc <= k_start + 8 * S);
    mon_vec_exp  = mon_busy_exp ? 3'((cyc - k_start - 1) / S) : 3'b000;
    check("busy", busy, mon_busy_exp);
    check("abc", {A, B, C}, mon_vec_exp);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("done_without_sweep", done, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("pass", pass, mon_e.pass);
        check("err_cnt", err_cnt, mon_e.err);
        check("fail_vec", fail_vec, mon_e.fvec);
      end
    end
  end

  task automatic at_cycle(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep(uut_mode_e m, bit push, int err, int fv, int ps);
    exp_t e;
    mode    = m;
    start   = 1'b1;
    k_start = cyc;
    active  = 1'b1;
    if (push) begin
      e.done_cyc = cyc + 8 * S + 1;
      e.err      = err;
      e.fvec     = fv;
      e.pass     = ps;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_vec"}, fail_vec, 0);
    check({tag, "_abc"}, {A, B, C}, 0);
  endtask

  initial begin
    @(negedge clk);
    at_cycle(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Good UUT, start at cycle 10; stray start during vector 3 is ignored.
    at_cycle(10);
    sweep(UUT_GOOD, 1'b1, 0, 0, 1);
    at_cycle(24);
    pulse_start();

    // Start coinciding with done is dropped; the next cycle's start is taken.
    at_cycle(43);
    pulse_start();
    check("pass_held_in_idle", pass, 1);
    sweep(UUT_E_STUCK0, 1'b1, 4, 3'b011, 0);
    check("pass_cleared_on_start", pass, 0);
    check("busy_after_start", busy, 1);

    // D inverted for vector 101 only.
    at_cycle(80);
    sweep(UUT_D_INV_101, 1'b1, 1, 3'b101, 0);

    // Abort with reset in vector 5; partial results must vanish.
    at_cycle(116);
    sweep(UUT_E_STUCK0, 1'b0, 0, 0, 0);
    at_cycle(138);
    check("abort_err_cnt_before", err_cnt, 1);
    check("abort_fail_vec_before", fail_vec, 3'b011);
    check("abort_abc_before", {A, B, C}, 3'b101);
    rst    = 1'b1;
    active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("after_abort");

    // Clean sweep after the abort.
    at_cycle(160);
    sweep(UUT_GOOD, 1'b1, 0, 0, 1);

    at_cycle(200);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_bist.md
FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 Parameter SETTLE, default 4: dwell cycles per vector, legal range 2..15.
REQ-002 Parameter NVEC, default 8: vector count, fixed to 2^3.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 A, B, C  out  1 each  stimulus to the full-adder UUT; A is the vector MSB, C the LSB.
REQ-007 D, E  in  1 each  UUT response; D is the sum, E is the carry.
REQ-008 busy  out  1  high while a sweep is in progress.
REQ-009 done  out  1  one-cycle pulse at the end of a sweep.
REQ-010 pass  out  1  sweep result; held until the next accepted start.
REQ-011 err_cnt  out  4  number of mismatching vectors in the last sweep (0..8).
REQ-012 fail_vec  out  3  first mismatching vector {A,B,C}; 0 when err_cnt==0.

Function
REQ-013 FSM states: IDLE, APPLY, DONE.
REQ-014 IDLE with start=1 -> APPLY; vector index=0, dwell=0, err_cnt=0, fail_vec=0, pass=0.
REQ-015 start is ignored in APPLY and DONE; no restart and no counter disturbance.
REQ-016 In APPLY, {A,B,C} equals the vector index for SETTLE consecutive cycles.
REQ-017 The dwell counter runs 0..SETTLE-1; D and E are sampled only when dwell==SETTLE-1.
REQ-018 Expected values: D_exp = A^B^C; E_exp = (A&B)|(A&C)|(B&C), computed from the applied vector.
REQ-019 On a mismatch in D or E: err_cnt increments by 1; fail_vec is loaded only on the first mismatch of the sweep.
REQ-020 After sampling, index increments and dwell returns to 0.
REQ-021 After sampling index 7, the next state is DONE; index does not wrap.
REQ-022 DONE lasts exactly one cycle: done=1, busy=0, pass=(err_cnt==0); the next state is IDLE.
REQ-023 In IDLE and DONE, {A,B,C}=000.
REQ-024 busy is 1 in APPLY only.
REQ-025 Timing: start sampled at edge k -> busy=1 from cycle k+1 -> vector v is driven in cycles k+1+v*SETTLE .. k+(v+1)*SETTLE -> done=1 in cycle k+8*SETTLE+1.
REQ-026 A start asserted in the same cycle as done is ignored; a start in the following IDLE cycle is accepted.
REQ-027 err_cnt never exceeds 8 and needs no saturation logic.

Reset
REQ-028 rst=1 at any edge forces IDLE, from any state.
REQ-029 rst=1 forces A=B=C=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, index=0, dwell=0.
REQ-030 Reset during APPLY aborts the sweep: no done pulse, partial results discarded.
REQ-031 rst takes priority over start in the same cycle.

Structure
REQ-032 Shared package fa_bist_pkg holds: state encoding (IDLE=2'd0, APPLY=2'd1, DONE=2'd2), SETTLE default, NVEC=8, and the index and err_cnt widths.
REQ-033 One combinational sub-module fa_ref_model (inputs A, B, C; outputs D_exp, E_exp) is instantiated for expected-value generation.
REQ-034 All outputs are registered; no combinational path runs from D or E to any output.

Verification
REQ-035 Correct full-adder UUT, SETTLE=4, start pulse at cycle 10 -> vectors 000..111 each held 4 cycles, done in cycle 43, pass=1, err_cnt=0, fail_vec=0.
REQ-036 UUT with E stuck at 0 -> err_cnt=4, fail_vec=3'b011, pass=0.
REQ-037 UUT with D inverted only for vector 101 -> err_cnt=1, fail_vec=3'b101, pass=0.
REQ-038 Pulse start again during APPLY (at vector 3) -> sweep unaffected; done still in cycle 43.
REQ-039 Assert rst during vector 5 of a sweep -> all outputs 0 on the next cycle and no done pulse; a later start runs a full clean sweep.
REQ-040 Assert start together with done -> ignored; start one cycle later -> new sweep begins and pass clears to 0.
